uart_cmd_master: RTL and testbench

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_pkg.sv | 46 ++++
 rtl/uart_cmd_master.sv | 210 +++++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command master: FSM state codes, command
// opcodes and the outgoing-byte selector.
package uart_cmd_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle     = 3'd0;
  localparam state_t StSend     = 3'd1;
  localparam state_t StWaitTx   = 3'd2;
  localparam state_t StWaitResp = 3'd3;
  localparam state_t StGap      = 3'd4;

  // Control
  localparam logic [7:0] OpCtlReset   = 8'h10, OpCtlPing    = 8'h11;
  localparam logic [7:0] OpCtlVersion = 8'h12, OpCtlStatus  = 8'h13;
  // Register reads
  localparam logic [7:0] OpRdReg0 = 8'h20, OpRdReg1 = 8'h21, OpRdReg2 = 8'h22, OpRdReg3 = 8'h23;
  localparam logic [7:0] OpRdReg4 = 8'h24, OpRdReg5 = 8'h25, OpRdReg6 = 8'h26, OpRdReg7 = 8'h27;
  // Register writes
  localparam logic [7:0] OpWrReg0 = 8'h30, OpWrReg1 = 8'h31, OpWrReg2 = 8'h32, OpWrReg3 = 8'h33;
  localparam logic [7:0] OpWrReg4 = 8'h34, OpWrReg5 = 8'h35, OpWrReg6 = 8'h36, OpWrReg7 = 8'h37;
  // Memory reads
  localparam logic [7:0] OpRdMem0 = 8'h40, OpRdMem1 = 8'h41, OpRdMem2 = 8'h42, OpRdMem3 = 8'h43;
  localparam logic [7:0] OpRdMem4 = 8'h44, OpRdMem5 = 8'h45, OpRdMem6 = 8'h46, OpRdMem7 = 8'h47;
  // Memory writes
  localparam logic [7:0] OpWrMem0 = 8'h50, OpWrMem1 = 8'h51, OpWrMem2 = 8'h52, OpWrMem3 = 8'h53;
  localparam logic [7:0] OpWrMem4 = 8'h54, OpWrMem5 = 8'h55, OpWrMem6 = 8'h56, OpWrMem7 = 8'h57;
  // Debug
  localparam logic [7:0] OpDbg0 = 8'hA0, OpDbg1 = 8'hA1, OpDbg2 = 8'hA2;
  localparam logic [7:0] OpDbg3 = 8'hA3, OpDbg4 = 8'hA4, OpDbg5 = 8'hA5;
  // Boot
  localparam logic [7:0] OpBoot = 8'hB0;

  // Byte idx of a frame: 0 is the opcode, 1..3 are data bytes LSB first.
  function automatic logic [7:0] tx_byte(input logic [7:0]  opcode,
                                         input logic [23:0] data,
                                         input logic [2:0]  idx);
    case (idx)
      3'd0:    tx_byte = opcode;
      3'd1:    tx_byte = data[7:0];
      3'd2:    tx_byte = data[15:8];
      default: tx_byte = data[23:16];
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_master.sv
// UART command master: sends opcode + up to 3 data bytes through an external
// byte transmitter, collects up to 3 response bytes, then enforces an idle gap.
// Optional response timeout enabled by defining UART_CMD_MASTER_TIMEOUT_EN.
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned GAP_CYCLES     = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_opcode,
  input  logic [1:0]  cmd_tx_len,
  input  logic [23:0] cmd_tx_data,
  input  logic [1:0]  cmd_rx_len,
  output logic        utx_send,
  output logic [7:0]  utx_data,
  input  logic        utx_busy,
  input  logic        urx_rec,
  input  logic [7:0]  urx_data,
  output logic        resp_valid,
  output logic [23:0] resp_data,
  output logic        resp_timeout
);

  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t        state_q, state_d;
  logic [7:0]    opcode_q, opcode_d;
  logic [1:0]    tx_len_q, tx_len_d;
  logic [1:0]    rx_len_q, rx_len_d;
  logic [23:0]   tx_data_q, tx_data_d;
  logic [2:0]    byte_idx_q, byte_idx_d;
  logic [1:0]    rx_idx_q, rx_idx_d;
  logic          busy_seen_q, busy_seen_d;
  logic          urx_rec_q;
  logic          utx_send_q, utx_send_d;
  logic [7:0]    utx_data_q, utx_data_d;
  logic          resp_valid_q, resp_valid_d;
  logic [23:0]   resp_data_q, resp_data_d;
  logic          resp_timeout_q, resp_timeout_d;
  logic [GapW-1:0] gap_cnt_q, gap_cnt_d;

  logic accept, rx_edge, tx_last, rx_last, gap_done, to_expired;

  // Gated by reset so the master never looks ready while held in reset.
  assign cmd_ready = (state_q == StIdle) && sys_rst_n;
  assign accept    = cmd_valid && cmd_ready;
  assign rx_edge   = urx_rec && !urx_rec_q;
  // byte_idx_q has already advanced past the byte just completed.
  assign tx_last   = (byte_idx_q == ({1'b0, tx_len_q} + 3'd1));
  assign rx_last   = (({1'b0, rx_idx_q} + 3'd1) == {1'b0, rx_len_q});
  // A zero-length gap still spends its single entry cycle in GAP.
  assign gap_done  = ((32'(gap_cnt_q) + 32'd1) >= GAP_CYCLES);

`ifdef UART_CMD_MASTER_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0] to_cnt_q, to_cnt_d;

  // Idle-cycle counter in WAIT_RESP, restarted by every received byte.
  always_comb begin
    to_cnt_d = to_cnt_q + TmoW'(1);
    if ((state_q != StWaitResp) || rx_edge) to_cnt_d = '0;
  end

  // Timeout counter register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) to_cnt_q <= '0;
    else            to_cnt_q <= to_cnt_d;
  end

  assign to_expired = ((32'(to_cnt_q) + 32'd1) >= TIMEOUT_CYCLES);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  // Without the timeout the master waits for the response indefinitely.
  assign to_expired = 1'b0;
`endif

  // Next-state logic for the transaction FSM and its datapath.
  always_comb begin
    state_d        = state_q;
    opcode_d       = opcode_q;
    tx_len_d       = tx_len_q;
    rx_len_d       = rx_len_q;
    tx_data_d      = tx_data_q;
    byte_idx_d     = byte_idx_q;
    rx_idx_d       = rx_idx_q;
    busy_seen_d    = busy_seen_q;
    utx_send_d     = 1'b0;
    utx_data_d     = utx_data_q;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    gap_cnt_d      = gap_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          opcode_d       = cmd_opcode;
          tx_len_d       = cmd_tx_len;
          rx_len_d       = cmd_rx_len;
          tx_data_d      = cmd_tx_data;
          byte_idx_d     = '0;
          rx_idx_d       = '0;
          resp_data_d    = '0;
          resp_timeout_d = 1'b0;
          state_d        = StSend;
        end
      end
      StSend: begin
        if (!utx_busy) begin
          utx_send_d  = 1'b1;
          utx_data_d  = tx_byte(opcode_q, tx_data_q, byte_idx_q);
          byte_idx_d  = byte_idx_q + 3'd1;
          busy_seen_d = 1'b0;
          state_d     = StWaitTx;
        end
      end
      StWaitTx: begin
        // A byte is done only after busy has been seen high and then low again.
        if (utx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          if (!tx_last) begin
            state_d = StSend;
          end else if (rx_len_q == 2'd0) begin
            state_d      = StGap;
            resp_valid_d = 1'b1;
            gap_cnt_d    = '0;
          end else begin
            state_d = StWaitResp;
          end
        end
      end
      StWaitResp: begin
        if (rx_edge) begin
          case (rx_idx_q)
            2'd0:    resp_data_d[7:0]   = urx_data;
            2'd1:    resp_data_d[15:8]  = urx_data;
            default: resp_data_d[23:16] = urx_data;
          endcase
          rx_idx_d = rx_idx_q + 2'd1;
          if (rx_last) begin
            state_d      = StGap;
            resp_valid_d = 1'b1;
            gap_cnt_d    = '0;
          end
        end else if (to_expired) begin
          state_d        = StGap;
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          gap_cnt_d      = '0;
        end
      end
      StGap: begin
        if (gap_done) state_d = StIdle;
        else          gap_cnt_d = gap_cnt_q + GapW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any transaction silently.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q        <= StIdle;
      opcode_q       <= '0;
      tx_len_q       <= '0;
      rx_len_q       <= '0;
      tx_data_q      <= '0;
      byte_idx_q     <= '0;
      rx_idx_q       <= '0;
      busy_seen_q    <= 1'b0;
      urx_rec_q      <= 1'b0;
      utx_send_q     <= 1'b0;
      utx_data_q     <= '0;
      resp_valid_q   <= 1'b0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
      gap_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      opcode_q       <= opcode_d;
      tx_len_q       <= tx_len_d;
      rx_len_q       <= rx_len_d;
      tx_data_q      <= tx_data_d;
      byte_idx_q     <= byte_idx_d;
      rx_idx_q       <= rx_idx_d;
      busy_seen_q    <= busy_seen_d;
      urx_rec_q      <= urx_rec;
      utx_send_q     <= utx_send_d;
      utx_data_q     <= utx_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      gap_cnt_q      <= gap_cnt_d;
    end
  end

  assign utx_send     = utx_send_q;
  assign utx_data     = utx_data_q;
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  // Constant 0 when the timeout is compiled out: nothing ever sets it.
  assign resp_timeout = resp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed self-checking bench for uart_cmd_master with a simple byte
// transmitter model (busy for 6 cycles per byte) and a hand-driven receiver.
module tb_uart_cmd_master;

  localparam int unsigned Gap = 16;
  localparam int unsigned Tmo = 100;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_opcode = '0;
  logic [1:0]  cmd_tx_len = '0;
  logic [23:0] cmd_tx_data = '0;
  logic [1:0]  cmd_rx_len = '0;
  logic        utx_send;
  logic [7:0]  utx_data;
  logic        utx_busy;
  logic        urx_rec = 1'b0;
  logic [7:0]  urx_data = '0;
  logic        resp_valid;
  logic [23:0] resp_data;
  logic        resp_timeout;

  always #5 sys_clk = ~sys_clk;

  uart_cmd_master #(
    .TIMEOUT_CYCLES(Tmo),
    .GAP_CYCLES    (Gap)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_tx_len  (cmd_tx_len),
    .cmd_tx_data (cmd_tx_data),
    .cmd_rx_len  (cmd_rx_len),
    .utx_send    (utx_send),
    .utx_data    (utx_data),
    .utx_busy    (utx_busy),
    .urx_rec     (urx_rec),
    .urx_data    (urx_data),
    .resp_valid  (resp_valid),
    .resp_data   (resp_data),
    .resp_timeout(resp_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitors and transmitter model, all sampling at the active edge.
  int         cyc = 0;
  int         busy_cnt = 0;
  int         send_while_busy = 0;
  int         resp_cnt = 0;
  int         resp_cyc = 0;
  int         acc_cnt = 0;
  int         gap_min = 1000000;
  int         rx_cyc = 0;
  logic       urx_prev = 1'b0;
  logic [7:0] tx_log[$];

  assign utx_busy = (busy_cnt != 0);

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    urx_prev <= urx_rec;
    if (urx_rec && !urx_prev) rx_cyc <= cyc;
    if (utx_send) begin
      tx_log.push_back(utx_data);
      if (utx_busy) send_while_busy <= send_while_busy + 1;
      busy_cnt <= 6;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (resp_valid) begin
      resp_cnt <= resp_cnt + 1;
      resp_cyc <= cyc;
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt <= acc_cnt + 1;
      if (resp_cnt > 0 && (cyc - resp_cyc) < gap_min) gap_min <= cyc - resp_cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [1:0] txl,
                          input logic [23:0] d, input logic [1:0] rxl);
    int t = 0;
    cmd_opcode  = op;
    cmd_tx_len  = txl;
    cmd_tx_data = d;
    cmd_rx_len  = rxl;
    cmd_valid   = 1'b1;
    while (!cmd_ready && t < 100) begin
      tick(1);
      t++;
    end
    check("cmd_accepted", {31'd0, cmd_ready}, 32'd1);
    tick(1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_tx_idle(input int n);
    int t = 0;
    while (!(tx_log.size() >= n && !utx_busy) && t < 300) begin
      tick(1);
      t++;
    end
    check("tx_bytes_sent", tx_log.size(), n);
    tick(3);
  endtask

  task automatic wait_resp(input int n);
    int t = 0;
    while (resp_cnt < n && t < 2000) begin
      tick(1);
      t++;
    end
    check("resp_valid_seen", resp_cnt, n);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    urx_data = d;
    urx_rec  = 1'b1;
    tick(2);
    urx_rec  = 1'b0;
    tick(1);
  endtask

  int r0, a0, t0;

  initial begin
    // Reset values
    tick(3);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_utx_send", {31'd0, utx_send}, 32'd0);
    check("rst_utx_data", {24'd0, utx_data}, 32'h0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", {8'd0, resp_data}, 32'h0);
    check("rst_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    sys_rst_n = 1'b1;
    tick(1);
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Opcode only, no response
    tx_log.delete();
    r0 = resp_cnt;
    send_cmd(8'h10, 2'd0, 24'h0, 2'd0);
    wait_resp(r0 + 1);
    check("t1_resp_pulse_width", {31'd0, resp_valid}, 32'd0);
    check("t1_tx_count", tx_log.size(), 1);
    check("t1_tx_byte0", {24'd0, tx_log[0]}, 32'h10);
    check("t1_resp_data", {8'd0, resp_data}, 32'h0);
    check("t1_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    check("t1_not_ready_in_gap", {31'd0, cmd_ready}, 32'd0);
    tick(Gap + 2);

    // Opcode plus one data byte
    tx_log.delete();
    r0 = resp_cnt;
    send_cmd(8'h31, 2'd1, 24'h00005A, 2'd0);
    wait_resp(r0 + 1);
    check("t2_tx_count", tx_log.size(), 2);
    check("t2_tx_byte0", {24'd0, tx_log[0]}, 32'h31);
    check("t2_tx_byte1", {24'd0, tx_log[1]}, 32'h5A);
    check("t2_no_send_while_busy", send_while_busy, 0);
    tick(Gap + 2);

    // One response byte; an rx edge during SEND must be ignored
    tx_log.delete();
    r0 = resp_cnt;
    send_cmd(8'h22, 2'd0, 24'h0, 2'd1);
    rx_byte(8'hEE);
    wait_tx_idle(1);
    rx_byte(8'hC3);
    wait_resp(r0 + 1);
    check("t3_tx_byte0", {24'd0, tx_log[0]}, 32'h22);
    check("t3_resp_data", {8'd0, resp_data}, 32'h0000C3);
    check("t3_resp_timeout", {31'd0, resp_timeout}, 32'd0);
    tick(Gap + 2);

    // Two response bytes; an extra rx edge in GAP is ignored
    tx_log.delete();
    r0 = resp_cnt;
    send_cmd(8'h23, 2'd0, 24'h0, 2'd2);
    wait_tx_idle(1);
    rx_byte(8'h11);
    rx_byte(8'h22);
    wait_resp(r0 + 1);
    check("t4_resp_data", {8'd0, resp_data}, 32'h002211);
    rx_byte(8'h99);
    tick(Gap);
    check("t4_gap_rx_ignored", {8'd0, resp_data}, 32'h002211);
    check("t4_single_resp", resp_cnt, r0 + 1);
    check("t4_ready_after_gap", {31'd0, cmd_ready}, 32'd1);

    // Response shorter than requested
    tx_log.delete();
    r0 = resp_cnt;
    send_cmd(8'h24, 2'd0, 24'h0, 2'd2);
    wait_tx_idle(1);
    rx_byte(8'h7E);
`ifdef UART_CMD_MASTER_TIMEOUT_EN
    wait_resp(r0 + 1);
    check("t5_resp_timeout", {31'd0, resp_timeout}, 32'd1);
    check("t5_resp_data", {8'd0, resp_data}, 32'h00007E);
    // Byte captured at edge E, GAP entered at E+Tmo, pulse sampled at E+Tmo+1.
    check("t5_timeout_latency", resp_cyc - rx_cyc, Tmo + 1);
`else
    tick(3 * Tmo);
    check("t5_still_waiting", resp_cnt, r0);
    check("t5_not_ready", {31'd0, cmd_ready}, 32'd0);
    rx_byte(8'h44);
    wait_resp(r0 + 1);
    check("t5_resp_data", {8'd0, resp_data}, 32'h00447E);
    check("t5_resp_timeout", {31'd0, resp_timeout}, 32'd0);
`endif
    tick(Gap + 2);

    // cmd_valid held high: successive accepts must be separated by the gap
    a0 = acc_cnt;
    r0 = resp_cnt;
    cmd_opcode  = 8'h10;
    cmd_tx_len  = 2'd0;
    cmd_tx_data = 24'h0;
    cmd_rx_len  = 2'd0;
    cmd_valid   = 1'b1;
    t0 = 0;
    while (acc_cnt < a0 + 3 && t0 < 500) begin
      tick(1);
      t0++;
    end
    cmd_valid = 1'b0;
    check("t6_accepts", acc_cnt - a0, 3);
    check("t6_gap_respected", {31'd0, gap_min >= Gap}, 32'd1);
    wait_resp(r0 + 3);
    tick(Gap + 2);

    // Reset while a byte is in flight: no completion, back to IDLE
    tx_log.delete();
    send_cmd(8'h31, 2'd1, 24'h0000A5, 2'd0);
    t0 = 0;
    while (!utx_busy && t0 < 50) begin
      tick(1);
      t0++;
    end
    check("t7_busy_reached", {31'd0, utx_busy}, 32'd1);
    r0 = resp_cnt;
    sys_rst_n = 1'b0;
    tick(1);
    check("t7_ready_in_reset", {31'd0, cmd_ready}, 32'd0);
    check("t7_utx_data_in_reset", {24'd0, utx_data}, 32'h0);
    tick(1);
    sys_rst_n = 1'b1;
    tick(40);
    check("t7_no_resp_valid", resp_cnt, r0);
    check("t7_idle_after_reset", {31'd0, cmd_ready}, 32'd1);
    check("t7_tx_count", tx_log.size(), 1);

    check("final_no_send_while_busy", send_while_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
